// File: rtl/mul_iter_pkg.sv
// Shared types and sizing helpers for the mul_iter shift-add multiplier.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_add_shift.sv
// One combinational shift-add step: conditionally accumulate the multiplicand,
// then shift the multiplicand left and the multiplier right.
module mul_add_shift
  import mul_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] prod_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  assign prod_next   = mplier[0] ? (prod + mcand) : prod;
  assign mcand_next  = mcand << 1;
  assign mplier_next = mplier >> 1;

endmodule

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Optional MUL_EARLY_EXIT_EN ends the run once no multiplier bits remain.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_r, state_next_s;
  logic [2*WIDTH-1:0] prod_r, mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r, done_r;

  logic [2*WIDTH-1:0] prod_next_s, mcand_next_s;
  logic [WIDTH-1:0]   mplier_next_s;
  logic               accept_s, last_step_s;

  mul_add_shift #(.WIDTH(WIDTH)) u_step (
    .prod        (prod_r),
    .mcand       (mcand_r),
    .mplier      (mplier_r),
    .prod_next   (prod_next_s),
    .mcand_next  (mcand_next_s),
    .mplier_next (mplier_next_s)
  );

  assign accept_s = start && (state_r != RUN);

`ifdef MUL_EARLY_EXIT_EN
  assign last_step_s = (cnt_r == LAST_CNT) || (mplier_next_s == {WIDTH{1'b0}});
`else
  assign last_step_s = (cnt_r == LAST_CNT);
`endif

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (last_step_s) state_next_s = DONE;
        else             state_next_s = RUN;
      end
      DONE: begin
        if (accept_s) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so start never reaches them combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_r   <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      prod_r   <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, op_a};
      mplier_r <= op_b;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      prod_r   <= prod_next_s;
      mcand_r  <= mcand_next_s;
      mplier_r <= mplier_next_s;
      cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      prod_r   <= prod_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign product_lo = prod_r[WIDTH-1:0];
  assign product_hi = prod_r[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter; latency expectations follow
// MUL_EARLY_EXIT_EN when that macro is defined for the build.
module tb_mul_iter;

  localparam int WIDTH = 16;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy, done;
  logic [WIDTH-1:0] product_lo, product_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int t0       = 0;
  bit seen_done;

  mul_iter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [WIDTH-1:0] b);
    int hi;
    hi = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i + 1;
    if (hi < 1) hi = 1;
    return EARLY ? hi : WIDTH;
  endfunction

  // Called at a negedge; start is accepted at the following posedge.
  task automatic launch(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    t0    = edge_cnt;
    start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " done low"}, {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_prod, input int lat);
    while (done !== 1'b1 && (edge_cnt - t0) < 64) @(negedge clk);
    check({tag, " latency"}, edge_cnt - t0, lat);
    check({tag, " product"}, {product_hi, product_lo}, exp_prod);
    check({tag, " busy in done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [31:0] exp_prod);
    launch(tag, a, b);
    wait_done(tag, exp_prod, exp_lat(b));
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({tag, " product hold"}, {product_hi, product_lo}, exp_prod);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    op_a    = WIDTH'($urandom);
    op_b    = WIDTH'($urandom);
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst product", {product_hi, product_lo}, 32'd0);
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-rst busy", {31'd0, busy}, 32'd0);
    check("post-rst done", {31'd0, done}, 32'd0);
    check("post-rst product", {product_hi, product_lo}, 32'd0);

    run_op("3x5", 16'd3, 16'd5, 32'h0000_000F);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

    // start pulse while busy must not re-capture operands
    launch("7x9", 16'd7, 16'd9);
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'd2;
    op_b  = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done("7x9", 32'd63, exp_lat(16'd9));

    // new start during the done cycle
    launch("b2b", 16'h1234, 16'h0010);
    wait_done("b2b", 32'h0001_2340, exp_lat(16'h0010));
    @(negedge clk);

    // asynchronous reset in the middle of a run
    launch("abort", 16'h00FF, 16'h00FF);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort product", {product_hi, product_lo}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort no done", {31'd0, seen_done}, 32'd0);
    run_op("ffxff", 16'h00FF, 16'h00FF, 32'h0000_FE01);

    run_op("op_b zero", 16'h1234, 16'h0000, 32'h0000_0000);
    run_op("0101x8", 16'h0101, 16'h0008, 32'h0000_0808);
    run_op("3x8000", 16'h0003, 16'h8000, 32'h0001_8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
